seg7_scan_reader: RTL and testbench

//   Reader end of the 7-segment display path: watches the multiplexed segment/anode lines driven toward
//   the display and recovers the 4-bit value shown on each digit.

---
 rtl/seg7_pkg.sv | 62 ++++++
 rtl/seg7_scan_reader_if.sv | 32 +++
 rtl/seg7_pattern_decode.sv | 29 ++
 rtl/seg7_scan_reader.sv | 122 ++++++++++++
 tb/tb_seg7_scan_reader.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared 7-segment definitions for the display driver, this reader and benches.
//   Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low (0 = lit).
//   Contents:
//     SEG_*_BIT   bit position of each segment inside the 7-bit vector
//     SEG_0..F    glyph patterns for hex digits 0..F
//     seg_decode  pattern -> {legal, value[3:0]}; hex_en makes A..F legal
package seg7_pkg;

  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Returns {legal, value}. Letter glyphs are only legal when hex_en is set;
  // value is meaningless when legal is 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg, input logic hex_en);
    logic [4:0] r;
    r = 5'b0_0000;
    case (seg)
      SEG_0: r = {1'b1, 4'h0};
      SEG_1: r = {1'b1, 4'h1};
      SEG_2: r = {1'b1, 4'h2};
      SEG_3: r = {1'b1, 4'h3};
      SEG_4: r = {1'b1, 4'h4};
      SEG_5: r = {1'b1, 4'h5};
      SEG_6: r = {1'b1, 4'h6};
      SEG_7: r = {1'b1, 4'h7};
      SEG_8: r = {1'b1, 4'h8};
      SEG_9: r = {1'b1, 4'h9};
      SEG_A: r = {hex_en, 4'hA};
      SEG_B: r = {hex_en, 4'hB};
      SEG_C: r = {hex_en, 4'hC};
      SEG_D: r = {hex_en, 4'hD};
      SEG_E: r = {hex_en, 4'hE};
      SEG_F: r = {hex_en, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_reader_if.sv
// seg7_scan_reader_if
//   Bundle between a multiplexed 7-segment driver and the scan reader.
//   Signals:
//     seg        7       segment lines {g,f,e,d,c,b,a}, active-low
//     an         NDIG    digit enables, active-low
//     digits     4*NDIG  recovered digit values, digit k at [4k+3:4k]
//     dig_valid  NDIG    digit k last committed a legal pattern
//     upd        1       one-cycle commit pulse
//     upd_idx    3       digit index belonging to upd
//     an_err     1       one-cycle pulse, more than one anode was low
//   Modports: master = display side (drives seg/an), slave = reader.
interface seg7_scan_reader_if #(
  parameter int NDIG = 4
);
  logic [6:0]        seg;
  logic [NDIG-1:0]   an;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   dig_valid;
  logic              upd;
  logic [2:0]        upd_idx;
  logic              an_err;

  modport master (
    output seg, an,
    input  digits, dig_valid, upd, upd_idx, an_err
  );

  modport slave (
    input  seg, an,
    output digits, dig_valid, upd, upd_idx, an_err
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode
//   Combinational segment-pattern decoder: seg[6:0] -> {legal, value[3:0]}.
//   Build option: define SEG7_HEX_DECODE_EN to accept the letter glyphs
//   A,b,C,d,E,F as values 10..15; otherwise they decode as illegal.
//   Ports:
//     seg    in   7  active-low segment pattern {g,f,e,d,c,b,a}
//     legal  out  1  pattern is a recognised digit
//     value  out  4  decoded value (only meaningful when legal=1)
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] value
);

`ifdef SEG7_HEX_DECODE_EN
  localparam logic HEX_EN = 1'b1;
`else
  localparam logic HEX_EN = 1'b0;
`endif

  logic [4:0] dec;

  assign dec   = seg_decode(seg, HEX_EN);
  assign legal = dec[4];
  assign value = dec[3:0];

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
//   Monitors multiplexed segment/anode lines and recovers the value shown on
//   each digit. A sample (an,seg) must repeat STABLE_CNT consecutive edges with
//   exactly one anode low before it commits to that digit's registers.
//   Build option: SEG7_HEX_DECODE_EN (see seg7_pattern_decode) makes A..F legal.
//   Parameters: NDIG (1..8) digits, STABLE_CNT (>=2) samples per commit.
//   Ports:
//     clk    in  system clock, rising edge
//     rst_n  in  synchronous reset, active-low
//     bus    seg7_scan_reader_if.slave: seg/an in; digits, dig_valid,
//            upd, upd_idx, an_err out
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CNT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  seg7_scan_reader_if.slave   bus
);

  localparam int CW = $clog2(STABLE_CNT + 1);

  logic [NDIG-1:0] an_reg;
  logic [6:0]      seg_reg;
  logic [CW-1:0]   run_cnt_reg;
  logic [CW-1:0]   run_cnt_next;
  logic            upd_reg;
  logic [2:0]      upd_idx_reg;
  logic            an_err_reg;

  logic [NDIG-1:0] an_low;
  logic            any_low;
  logic            multi_low;
  logic            one_hot;
  logic            same_sample;
  logic            commit;
  logic [2:0]      idx;
  logic            dec_legal;
  logic [3:0]      dec_value;

  seg7_pattern_decode u_decode (
    .seg   (bus.seg),
    .legal (dec_legal),
    .value (dec_value)
  );

  assign an_low    = ~bus.an;
  assign any_low   = |an_low;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_low = (an_low & (an_low - 1'b1)) != '0;
  assign one_hot   = any_low && !multi_low;

  // run_cnt_reg==0 marks the held sample as stale (after reset/blank/error).
  assign same_sample = (bus.an == an_reg) && (bus.seg == seg_reg) && (run_cnt_reg != '0);

  always_comb begin
    run_cnt_next = '0;
    if (!one_hot) begin
      run_cnt_next = '0;
    end else if (same_sample) begin
      run_cnt_next = (run_cnt_reg == CW'(STABLE_CNT)) ? run_cnt_reg : run_cnt_reg + 1'b1;
    end else begin
      run_cnt_next = CW'(1);
    end
  end

  // Fires only on the STABLE_CNT-1 -> STABLE_CNT step; saturation blocks repeats.
  assign commit = one_hot && same_sample && (run_cnt_reg == CW'(STABLE_CNT - 1));

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (an_low[i]) idx = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_reg      <= '1;
      seg_reg     <= '1;
      run_cnt_reg <= '0;
      upd_reg     <= 1'b0;
      upd_idx_reg <= '0;
      an_err_reg  <= 1'b0;
    end else begin
      an_reg      <= bus.an;
      seg_reg     <= bus.seg;
      run_cnt_reg <= run_cnt_next;
      upd_reg     <= commit;
      if (commit) upd_idx_reg <= idx;
      an_err_reg  <= multi_low;
    end
  end

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      logic [3:0] digit_reg;
      logic       valid_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          digit_reg <= 4'h0;
          valid_reg <= 1'b0;
        end else if (commit && (idx == 3'(gi))) begin
          // Illegal glyphs keep the last good value but drop the valid flag.
          if (dec_legal) digit_reg <= dec_value;
          valid_reg <= dec_legal;
        end
      end

      assign bus.digits[4*gi +: 4] = digit_reg;
      assign bus.dig_valid[gi]     = valid_reg;
    end
  endgenerate

  assign bus.upd     = upd_reg;
  assign bus.upd_idx = upd_idx_reg;
  assign bus.an_err  = an_err_reg;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader
//   Directed scenarios plus randomized scan traffic, checked against a
//   reference model that counts consecutive identical samples and decodes
//   glyphs from its own pattern table.
module tb_seg7_scan_reader;

  localparam int NDIG       = 4;
  localparam int STABLE_CNT = 4;

`ifdef SEG7_HEX_DECODE_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic clk;
  logic rst_n;

  seg7_scan_reader_if #(.NDIG(NDIG)) bus ();

  seg7_scan_reader #(.NDIG(NDIG), .STABLE_CNT(STABLE_CNT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Glyph table, index = value 0..15.
  logic [6:0] pat_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [3:0] m_dig [NDIG];
  logic       m_val [NDIG];
  logic [3:0] m_an;
  logic [6:0] m_seg;
  int         m_run;
  logic       exp_upd;
  logic [2:0] exp_idx;
  logic       exp_err;

  int upd_log [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_digits();
    logic [15:0] r;
    for (int k = 0; k < NDIG; k++) r[4*k +: 4] = m_dig[k];
    return r;
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] r;
    for (int k = 0; k < NDIG; k++) r[k] = m_val[k];
    return r;
  endfunction

  task automatic model_edge(input logic r, input logic [3:0] a, input logic [6:0] s);
    int nlow;
    int k;
    int v;
    if (!r) begin
      for (int i = 0; i < NDIG; i++) begin
        m_dig[i] = 4'h0;
        m_val[i] = 1'b0;
      end
      m_run   = 0;
      exp_upd = 1'b0;
      exp_idx = 3'd0;
      exp_err = 1'b0;
      return;
    end
    nlow    = $countones(~a);
    exp_err = (nlow > 1);
    exp_upd = 1'b0;
    if (nlow != 1) begin
      m_run = 0;
    end else begin
      if (m_run > 0 && a == m_an && s == m_seg) m_run++;
      else m_run = 1;
      if (m_run == STABLE_CNT) begin
        k = 0;
        for (int i = 0; i < NDIG; i++) if (!a[i]) k = i;
        v = -1;
        for (int i = 0; i < 16; i++) if (pat_tab[i] == s && (i < 10 || HEX)) v = i;
        if (v >= 0) begin
          m_dig[k] = 4'(v);
          m_val[k] = 1'b1;
        end else begin
          m_val[k] = 1'b0;
        end
        exp_upd = 1'b1;
        exp_idx = 3'(k);
      end
    end
    m_an  = a;
    m_seg = s;
  endtask

  // One clock: drive, clock, update model, compare outputs.
  task automatic step(input logic r, input logic [3:0] a, input logic [6:0] s);
    rst_n   = r;
    bus.an  = a;
    bus.seg = s;
    @(posedge clk);
    model_edge(r, a, s);
    #1;
    chk("upd", 32'(bus.upd), 32'(exp_upd));
    chk("an_err", 32'(bus.an_err), 32'(exp_err));
    chk("digits", 32'(bus.digits), 32'(model_digits()));
    chk("dig_valid", 32'(bus.dig_valid), 32'(model_valid()));
    if (bus.upd || exp_upd) chk("upd_idx", 32'(bus.upd_idx), 32'(exp_idx));
    if (bus.upd) begin
      upd_log.push_back(int'(bus.upd_idx));
      $display("[TB] commit idx=%0d digits=%h valid=%b", bus.upd_idx, bus.digits, bus.dig_valid);
    end
  endtask

  task automatic hold(input int n, input logic [3:0] a, input logic [6:0] s);
    for (int i = 0; i < n; i++) step(1'b1, a, s);
  endtask

  initial begin
    logic [3:0] cur_an;
    logic [6:0] cur_seg;
    logic [3:0] scan_an [4];
    int         scan_val [4];
    int         exp_order [8];

    m_an  = 4'hF;
    m_seg = 7'h7F;
    m_run = 0;

    // Reset from power-up.
    step(1'b0, 4'hF, 7'h7F);
    step(1'b0, 4'hF, 7'h7F);

    // Digit 0 shows "2": commits after STABLE_CNT samples, then stays silent.
    hold(4, 4'b1110, pat_tab[2]);
    chk("t2_upd", 32'(bus.upd), 32'd1);
    chk("t2_digit0", 32'(bus.digits[3:0]), 32'h2);
    upd_log.delete();
    hold(10, 4'b1110, pat_tab[2]);
    chk("t2_no_repeat", 32'(upd_log.size()), 32'd0);

    // Short run on digit 1 interrupted by blanking: no commit.
    hold(3, 4'b1101, pat_tab[3]);
    hold(1, 4'b1111, 7'h7F);
    chk("t3_no_commit", 32'(upd_log.size()), 32'd0);
    chk("t3_valid1", 32'(bus.dig_valid[1]), 32'd0);

    // Letter A on digit 2.
    hold(4, 4'b1011, pat_tab[10]);
    chk("t4_valid2", 32'(bus.dig_valid[2]), 32'(HEX));
    chk("t4_digit2", 32'(bus.digits[11:8]), HEX ? 32'hA : 32'h0);

    // Two anodes low: single an_err pulse.
    hold(1, 4'b1100, pat_tab[8]);
    chk("t5_err", 32'(bus.an_err), 32'd1);
    hold(1, 4'b1111, 7'h7F);
    chk("t5_err_clear", 32'(bus.an_err), 32'd0);

    // Full scan looped twice.
    scan_an  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    scan_val = '{9, 8, 7, 1};
    exp_order = '{3, 2, 1, 0, 3, 2, 1, 0};
    upd_log.delete();
    for (int lp = 0; lp < 2; lp++) begin
      for (int d = 0; d < 4; d++) begin
        hold(6, scan_an[d], pat_tab[scan_val[d]]);
        hold(1, 4'b1111, 7'h7F);
      end
    end
    chk("t6_digits", 32'(bus.digits), 32'h9871);
    chk("t6_valid", 32'(bus.dig_valid), 32'hF);
    chk("t6_upd_count", 32'(upd_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < upd_log.size()) chk("t6_order", 32'(upd_log[i]), 32'(exp_order[i]));
    end

    // Reset mid-run, then a fresh run needs the full count.
    hold(2, 4'b1110, pat_tab[5]);
    step(1'b0, 4'b1110, pat_tab[5]);
    step(1'b0, 4'b1110, pat_tab[5]);
    chk("t1_digits", 32'(bus.digits), 32'h0);
    chk("t1_valid", 32'(bus.dig_valid), 32'h0);
    hold(3, 4'b1110, pat_tab[5]);
    chk("t1_early", 32'(bus.upd), 32'd0);
    hold(1, 4'b1110, pat_tab[5]);
    chk("t1_commit", 32'(bus.upd), 32'd1);
    chk("t1_digit0", 32'(bus.digits[3:0]), 32'h5);

    // Randomized scan traffic.
    cur_an  = 4'hF;
    cur_seg = 7'h7F;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) < 25) begin
        int sel;
        sel = $urandom_range(99);
        if (sel < 65) begin
          cur_an = 4'hF;
          cur_an[$urandom_range(NDIG - 1)] = 1'b0;
        end else if (sel < 85) begin
          cur_an = 4'hF;
        end else begin
          cur_an = 4'($urandom);
        end
        if ($urandom_range(99) < 80) cur_seg = pat_tab[$urandom_range(15)];
        else cur_seg = 7'($urandom);
      end
      step(($urandom_range(299) == 0) ? 1'b0 : 1'b1, cur_an, cur_seg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
